// File: rtl/song_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_sequencer_pkg : shared state encoding, ROM field layout, note maps  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int END_BIT  = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 5;
  localparam int NOTE_MSB = 4;

  localparam logic [4:0] NOTE_REST     = 5'd0;
  localparam int         NOTES_PER_OCT = 7;

  function automatic logic [1:0] note_octave(input logic [4:0] code);
    if (code == NOTE_REST) return 2'd0;
    return 2'((int'(code) - 1) / NOTES_PER_OCT);
  endfunction

  function automatic logic [6:0] note_led(input logic [4:0] code);
    if (code == NOTE_REST) return 7'd0;
    return 7'd1 << ((int'(code) - 1) % NOTES_PER_OCT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_rom.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_rom : synchronous 512x9 song table, one-cycle read latency          |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module song_rom
  import song_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic [8:0] addr,
  output logic [8:0] data
);

  logic [8:0] data_d;
  logic [8:0] data_q;

  // Entry layout {end, dur[2:0], note[4:0]}; unlisted addresses read as end markers.
  always_comb begin
    data_d = {1'b1, 8'h00};
    case (addr)
      9'd0:    data_d = {1'b0, 3'd2, 5'd1};
      9'd1:    data_d = {1'b0, 3'd2, 5'd2};
      9'd2:    data_d = {1'b0, 3'd4, 5'd3};
      9'd64:   data_d = {1'b0, 3'd2, 5'd1};
      9'd65:   data_d = {1'b0, 3'd1, NOTE_REST};
      9'd66:   data_d = {1'b0, 3'd1, 5'd8};
      9'd128:  data_d = {1'b0, 3'd1, 5'd15};
      9'd129:  data_d = {1'b0, 3'd1, 5'd17};
      9'd130:  data_d = {1'b0, 3'd3, 5'd19};
      default: data_d = {1'b1, 8'h00};
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_sequencer : walks a song table, times notes, drives tone gen + LEDs |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int IDX_W       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         select,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic [IDX_W+2:0]   rom_addr,
  input  logic [8:0]         rom_data,
  output logic [4:0]         note_code,
  output logic               note_valid,
  output logic [1:0]         octave,
  output logic [6:0]         led,
  output logic               busy,
  output logic               song_done
);

  localparam int CNT_MAX = (7 * UNIT_CYCLES > GAP_CYCLES) ? 7 * UNIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_e             state_d, state_q;
  logic [2:0]         song_d, song_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [4:0]         note_d, note_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [2:0]         dur_eff;

  assign dur_eff = (rom_data[DUR_MSB:DUR_LSB] == 3'd0) ? 3'd1 : rom_data[DUR_MSB:DUR_LSB];

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = ST_IDLE;
      song_d  = 3'd0;
      idx_d   = '0;
      note_d  = NOTE_REST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            song_d  = select;
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (rom_data[END_BIT]) begin
            state_d = ST_DONE;
          end else begin
            note_d  = rom_data[NOTE_MSB:0];
            cnt_d   = CNT_W'(int'(dur_eff) * UNIT_CYCLES - 1);
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!pause) begin
            if (cnt_q == '0) begin
              cnt_d   = CNT_W'(GAP_CYCLES - 1);
              state_d = ST_GAP;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (!pause) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      song_q  <= 3'd0;
      idx_q   <= '0;
      note_q  <= NOTE_REST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pause gates the tone combinationally so the silence lines up with the frozen count.
  assign note_valid = (state_q == ST_PLAY) && !pause && (note_q != NOTE_REST);
  assign note_code  = note_valid ? note_q : NOTE_REST;
  assign octave     = note_octave(note_code);
  assign led        = note_led(note_code);
  assign busy       = (state_q != ST_IDLE);
  assign song_done  = (state_q == ST_DONE) && !stop;
  assign rom_addr   = {song_q, idx_q};

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_song_sequencer : randomized scoreboard bench, IDX_W=6 and IDX_W=2 DUTs|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_song_sequencer;

  localparam int U    = 4;
  localparam int G    = 2;
  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst, start, pause, stop, use_hw;
  logic [2:0] select;

  logic [8:0] rom_addr1, rom_data1, emu1, hw_data;
  logic [4:0] note_code1;
  logic       note_valid1, busy1, song_done1;
  logic [1:0] octave1;
  logic [6:0] led1;

  logic [4:0] rom_addr2;
  logic [8:0] emu2;
  logic [4:0] note_code2;
  logic       note_valid2, busy2, song_done2;
  logic [1:0] octave2;
  logic [6:0] led2;

  logic [8:0] mem1 [512];
  logic [8:0] mem2 [32];

  always #5 clk = ~clk;

  song_sequencer #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .IDX_W(6)) dut1 (
    .clk(clk), .rst(rst), .select(select), .start(start), .pause(pause), .stop(stop),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .note_code(note_code1),
    .note_valid(note_valid1), .octave(octave1), .led(led1), .busy(busy1),
    .song_done(song_done1));

  song_sequencer #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .IDX_W(2)) dut2 (
    .clk(clk), .rst(rst), .select(select), .start(start), .pause(pause), .stop(stop),
    .rom_addr(rom_addr2), .rom_data(emu2), .note_code(note_code2),
    .note_valid(note_valid2), .octave(octave2), .led(led2), .busy(busy2),
    .song_done(song_done2));

  song_rom u_rom (.clk(clk), .addr(rom_addr1), .data(hw_data));

  always @(posedge clk) begin
    emu1 <= mem1[rom_addr1];
    emu2 <= mem2[rom_addr2];
  end
  assign rom_data1 = use_hw ? hw_data : emu1;

  typedef struct {
    logic       busy;
    logic       nv;
    logic [4:0] code;
    logic [1:0] oct;
    logic [6:0] led;
    logic       done;
    logic       chk;
    logic [8:0] addr;
  } exp_t;

  exp_t       tr1 [MAXC];
  exp_t       tr2 [MAXC];
  exp_t       q1 [$];
  exp_t       q2 [$];
  bit         pz    [MAXC];
  bit         st_a  [MAXC];
  bit         stp_a [MAXC];
  bit         rs_a  [MAXC];
  logic [2:0] sel_a [MAXC];
  int         tests = 0;
  int         fails = 0;

  function automatic exp_t mk(input bit b, input int n, input bit dn, input bit chk, input int addr);
    exp_t e;
    e.busy = b;
    e.nv   = (n > 0);
    e.code = 5'(n);
    e.oct  = (n > 0) ? 2'((n - 1) / 7) : 2'd0;
    e.led  = (n > 0) ? 7'(1 << ((n - 1) % 7)) : 7'd0;
    e.done = dn;
    e.chk  = chk;
    e.addr = 9'(addr);
    return e;
  endfunction

  task automatic put(input int w, input int c, input exp_t e);
    if (c < MAXC) begin
      if (w == 1) tr1[c] = e;
      else        tr2[c] = e;
    end
  endtask

  // Timeline model: each note consumes dur*U unpaused cycles, each gap G unpaused cycles,
  // and every table entry costs two unpausable fetch cycles before it takes effect.
  task automatic gen(input int w, input int idxw, input int song, output int len);
    int c, idx, ticks, n, d, base;
    logic [8:0] ent;
    bit fin;
    c = 1; idx = 0; fin = 1'b0;
    while (!fin && c < MAXC - 8) begin
      base = song * (1 << idxw) + idx;
      put(w, c, mk(1, 0, 0, 1, base));
      put(w, c + 1, mk(1, 0, 0, 1, base));
      c += 2;
      ent = (w == 1) ? mem1[base] : mem2[base];
      if (ent[8]) begin
        put(w, c, mk(1, 0, 1, 1, base));
        c++;
        fin = 1'b1;
      end else begin
        n = int'(ent[4:0]);
        d = (ent[7:5] == 3'd0) ? 1 : int'(ent[7:5]);
        ticks = d * U;
        while (ticks > 0 && c < MAXC - 8) begin
          if (pz[c]) put(w, c, mk(1, 0, 0, 1, base));
          else begin put(w, c, mk(1, n, 0, 1, base)); ticks--; end
          c++;
        end
        ticks = G;
        while (ticks > 0 && c < MAXC - 8) begin
          put(w, c, mk(1, 0, 0, 1, base));
          if (!pz[c]) ticks--;
          c++;
        end
        if (idx == (1 << idxw) - 1) begin
          put(w, c, mk(1, 0, 1, 1, base));
          c++;
          fin = 1'b1;
        end else begin
          idx++;
        end
      end
    end
    len = c;
  endtask

  task automatic run(input int mode, input logic [2:0] song, input int prate,
                     input int pst, input int plen, input int sfix, input bit hw);
    int len1, len2, n, s, mn;
    for (int c = 0; c < MAXC; c++) begin
      pz[c]    = (prate > 0) && ($urandom_range(prate - 1) == 0);
      st_a[c]  = 1'b0;
      stp_a[c] = 1'b0;
      rs_a[c]  = 1'b0;
      sel_a[c] = (c == 0) ? song : 3'($urandom);
      tr1[c]   = mk(0, 0, 0, 0, 0);
      tr2[c]   = mk(0, 0, 0, 0, 0);
    end
    for (int c = pst; c < pst + plen; c++) pz[c] = 1'b1;
    st_a[0] = 1'b1;
    if (mode == 3) begin
      stp_a[0] = 1'b1;
      n = 6;
    end else begin
      gen(1, 6, int'(song), len1);
      gen(2, 2, int'(song), len2);
      n  = ((len1 > len2) ? len1 : len2) + 3;
      mn = (len1 < len2) ? len1 : len2;
      if (mode == 1 || mode == 2) begin
        s = (sfix > 0) ? sfix : int'($urandom_range(1, mn - 1));
        if (mode == 1) begin
          stp_a[s] = 1'b1;
          tr1[s].done = 1'b0;
          tr2[s].done = 1'b0;
        end else begin
          rs_a[s] = 1'b1;
        end
        for (int c = s + 1; c < n; c++) begin
          tr1[c] = mk(0, 0, 0, 1, 0);
          tr2[c] = mk(0, 0, 0, 1, 0);
        end
      end
      for (int c = 1; c < n; c++)
        if (tr1[c].busy && tr2[c].busy && $urandom_range(15) == 0) st_a[c] = 1'b1;
    end
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      use_hw = hw;
      start  = st_a[c];
      stop   = stp_a[c];
      rst    = rs_a[c];
      pause  = pz[c];
      select = sel_a[c];
      q1.push_back(tr1[c]);
      q2.push_back(tr2[c]);
    end
  endtask

  task automatic check(input int w, input exp_t e, input logic b, input logic nv,
                       input logic [4:0] code, input logic [1:0] oct, input logic [6:0] ld,
                       input logic dn, input logic [8:0] addr);
    bit ok;
    ok = (b === e.busy) && (nv === e.nv) && (code === e.code) && (oct === e.oct) &&
         (ld === e.led) && (dn === e.done) && (!e.chk || addr === e.addr);
    tests++;
    if (!ok) begin
      fails++;
      if (fails <= 30)
        $display("FAIL dut%0d_cycle t=%0t got busy=%b nv=%b code=%0d oct=%0d led=%b done=%b addr=%0h want busy=%b nv=%b code=%0d oct=%0d led=%b done=%b addr=%0h(chk=%b)",
                 w, $time, b, nv, code, oct, ld, dn, addr,
                 e.busy, e.nv, e.code, e.oct, e.led, e.done, e.addr, e.chk);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(1, e, busy1, note_valid1, note_code1, octave1, led1, song_done1, rom_addr1);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check(2, e, busy2, note_valid2, note_code2, octave2, led2, song_done2,
              {4'd0, rom_addr2});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, sg, len, prate;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; select = 3'd0; use_hw = 1'b0;
    for (int i = 0; i < 512; i++) mem1[i] = 9'h100;
    for (int i = 0; i < 32; i++)  mem2[i] = {1'b0, 3'(i), 5'((i % 21) + 1)};
    mem1[64] = {1'b0, 3'd2, 5'd1};
    mem1[65] = {1'b0, 3'd1, 5'd0};
    mem1[66] = {1'b0, 3'd1, 5'd8};
    mem1[67] = 9'h100;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      q1.push_back(mk(0, 0, 0, 1, 0));
      q2.push_back(mk(0, 0, 0, 1, 0));
      @(posedge clk); #1;
    end
    run(0, 3'd1, 0, 0, 0, 0, 1'b1);
    run(0, 3'd1, 0, 5, 3, 0, 1'b1);
    run(1, 3'd1, 0, 0, 0, 5, 1'b1);
    run(3, 3'd1, 0, 0, 0, 0, 1'b1);
    run(2, 3'd1, 0, 0, 0, 6, 1'b1);
    for (int r = 0; r < 40; r++) begin
      sg  = int'($urandom_range(7));
      len = int'($urandom_range(7));
      for (int i = 0; i < len; i++)
        mem1[sg * 64 + i] = {1'b0, 3'($urandom),
                             ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(1, 21))};
      mem1[sg * 64 + len] = {1'b1, 8'($urandom)};
      for (int i = 0; i < 4; i++)
        mem2[sg * 4 + i] = {($urandom_range(7) == 0), 3'($urandom),
                            5'($urandom_range(0, 21))};
      m = int'($urandom_range(5));
      m = (m <= 2) ? 0 : m - 2;
      prate = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 4 : 8);
      run(m, 3'(sg), prate, 0, 0, 0, 1'b0);
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL drain: queues not empty q1=%0d q2=%0d want 0", q1.size(), q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
